// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared constants and helpers for the debounce scan controller.
// Event word layout: [EVT_W-1:EVT_CH_LSB] channel index, [EVT_RISE_BIT] edge direction.
package debounce_scan_ctrl_pkg;

  localparam int unsigned EVT_RISE_BIT = 0;
  localparam int unsigned EVT_CH_LSB   = 1;

  // Index width for n items, never below 1 bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Total event word width for a given channel count.
  function automatic int unsigned evt_w(input int unsigned num_ch);
    return EVT_CH_LSB + chan_w(num_ch);
  endfunction

endpackage

// File: rtl/debounce_evt_fifo.sv
// Synchronous event FIFO with full/empty flags.
// A push while full is accepted when a pop happens in the same cycle.
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   push, push_data     : write request and data (ignored when full without pop)
//   pop                 : read request (ignored when empty)
//   head                : data at the FIFO head
//   full, empty         : occupancy flags
module debounce_evt_fifo
  import debounce_scan_ctrl_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = chan_w(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Multi-channel debounce controller sharing one counter/compare datapath.
// Channels are served round-robin on a prescaled tick; accepted level changes
// are queued as events toward the host control path.
// Optional macro DEBOUNCE_SCAN_MASK_EN adds a per-channel event mask input.
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   in                  : raw asynchronous inputs
//   mask                : (DEBOUNCE_SCAN_MASK_EN) 1 = suppress events of channel
//   state               : debounced levels
//   evt_valid/evt_ready : event handshake, head = {evt_channel, evt_rise}
//   overflow            : sticky event-dropped flag, cleared by overflow_clr
module debounce_scan_ctrl
  import debounce_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MAX_COUNT  = 16,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         in,
`ifdef DEBOUNCE_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]         mask,
`endif
  output logic [NUM_CH-1:0]         state,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [chan_w(NUM_CH)-1:0] evt_channel,
  output logic                      evt_rise,
  output logic                      overflow,
  input  logic                      overflow_clr
);

  localparam int unsigned CH_W  = chan_w(NUM_CH);
  localparam int unsigned CNT_W = chan_w(MAX_COUNT);
  localparam int unsigned DIV_W = chan_w(TICK_DIV);
  localparam int unsigned EW    = evt_w(NUM_CH);

  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic [NUM_CH-1:0] r_state;
  logic [DIV_W-1:0]  r_div;
  logic [CH_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic              r_ovf;

  logic              w_tick;
  logic              w_s_p;
  logic              w_st_p;
  logic [CNT_W-1:0]  w_cnt_p;
  logic              w_accept;
  logic              w_mask_p;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [EW-1:0]     w_head;

  assign w_tick   = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_s_p    = r_s2[r_ptr];
  assign w_st_p   = r_state[r_ptr];
  assign w_cnt_p  = r_cnt[r_ptr];
  assign w_accept = w_tick && (w_s_p != w_st_p) && (w_cnt_p == CNT_W'(MAX_COUNT - 1));
`ifdef DEBOUNCE_SCAN_MASK_EN
  assign w_mask_p = mask[r_ptr];
`else
  assign w_mask_p = 1'b0;
`endif
  assign w_push   = w_accept && !w_mask_p;
  assign w_pop    = evt_valid && evt_ready;

  // Two-flop synchronizer per channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in;
      r_s2 <= r_s1;
    end
  end

  // Sample-tick prescaler and round-robin channel pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
      r_ptr <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_ptr <= (r_ptr == CH_W'(NUM_CH - 1)) ? '0 : r_ptr + CH_W'(1);
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Shared debounce datapath: only the served channel's counter/state move.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      if (w_s_p == w_st_p) begin
        r_cnt[r_ptr] <= '0;
      end else if (w_accept) begin
        r_state[r_ptr] <= w_s_p;
        r_cnt[r_ptr]   <= '0;
      end else begin
        r_cnt[r_ptr] <= w_cnt_p + CNT_W'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle wins over the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (overflow_clr) begin
      r_ovf <= 1'b0;
    end
  end

  debounce_evt_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data ({r_ptr, w_s_p}),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign state       = r_state;
  assign overflow    = r_ovf;
  assign evt_valid   = !w_empty;
  assign evt_channel = w_head[EW-1:EVT_CH_LSB];
  assign evt_rise    = w_head[EVT_RISE_BIT];

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl with a cycle-level reference model.
module tb_debounce_scan_ctrl;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned MAX_COUNT  = 4;
  localparam int unsigned TICK_DIV   = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in_v = '0;
`ifdef DEBOUNCE_SCAN_MASK_EN
  logic [3:0] mask_v = '0;
`endif
  logic       evt_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [3:0] state;
  logic       evt_valid;
  logic [1:0] evt_channel;
  logic       evt_rise;
  logic       overflow;

  always #5 clock = ~clock;

  debounce_scan_ctrl #(
    .NUM_CH(NUM_CH), .MAX_COUNT(MAX_COUNT), .TICK_DIV(TICK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in           (in_v),
`ifdef DEBOUNCE_SCAN_MASK_EN
    .mask         (mask_v),
`endif
    .state        (state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_channel  (evt_channel),
    .evt_rise     (evt_rise),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: clocks since reset give tick and served channel directly.
  int         m_cyc;
  logic [3:0] m_d1, m_d2, m_state;
  int         m_cnt [4];
  int         m_q [$];
  logic       m_ovf;

  task automatic model_reset();
    m_cyc = 0; m_d1 = '0; m_d2 = '0; m_state = '0; m_ovf = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_q.delete();
  endtask

  function automatic bit m_masked(input int ch);
`ifdef DEBOUNCE_SCAN_MASK_EN
    return mask_v[ch];
`else
    return (ch < 0);
`endif
  endfunction

  function automatic bit m_will_push();
    int ch;
    ch = (m_cyc / TICK_DIV) % NUM_CH;
    return ((m_cyc % TICK_DIV) == TICK_DIV - 1) && (m_d2[ch] != m_state[ch]) &&
           (m_cnt[ch] == MAX_COUNT - 1) && !m_masked(ch);
  endfunction

  task automatic model_edge();
    bit pop, tick, push, drop, s;
    int ch;
    pop  = (m_q.size() != 0) && evt_ready;
    tick = (m_cyc % TICK_DIV) == TICK_DIV - 1;
    ch   = (m_cyc / TICK_DIV) % NUM_CH;
    s    = m_d2[ch];
    push = 1'b0;
    if (tick) begin
      if (s == m_state[ch]) m_cnt[ch] = 0;
      else if (m_cnt[ch] == MAX_COUNT - 1) begin
        m_state[ch] = s;
        m_cnt[ch]   = 0;
        push        = !m_masked(ch);
      end else m_cnt[ch]++;
    end
    drop = push && (m_q.size() == FIFO_DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(ch * 2 + int'(s));
    if (drop) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
    m_d2 = m_d1;
    m_d1 = in_v;
    m_cyc++;
  endtask

  task automatic compare_all();
    chk("state", state, m_state);
    chk("evt_valid", evt_valid, m_q.size() != 0);
    chk("overflow", overflow, m_ovf);
    if (m_q.size() != 0) begin
      chk("head_ch", evt_channel, m_q[0] >> 1);
      chk("head_rise", evt_rise, m_q[0] & 1);
    end
  endtask

  // Advance one clock: model follows the edge, outputs compared at the negedge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic hold_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) begin
      in_v = 4'($urandom);
      @(negedge clock);
      chk("rst_state", state, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_ch", evt_channel, 0);
      chk("rst_rise", evt_rise, 0);
    end
    reset_n = 1'b1;
  endtask

  int  vcnt, pops;
  bit  hit;

  initial begin
    model_reset();
    @(negedge clock);
    hold_reset(6);

    // ch0 partially counted, then reset mid-count: must start over.
    in_v = 4'b0001;
    repeat (20) step();
    chk("pre_reset_ch0", state[0], 0);
    hold_reset(3);
    in_v = 4'b0001;
    repeat (50) step();
    chk("ch0_after_reset", state[0], 1);

    // ch2 rises with ready high: a single one-clock event.
    in_v = 4'b0101;
    evt_ready = 1'b1;
    vcnt = 0;
    repeat (50) begin
      step();
      vcnt += int'(evt_valid);
    end
    chk("ch2_valid_cycles", vcnt, 1);
    chk("ch2_state", state[2], 1);

    // Short pulse on ch1 is rejected.
    in_v = 4'b0111;
    repeat (12) step();
    in_v = 4'b0101;
    repeat (40) step();
    chk("ch1_glitch", state[1], 0);

    // Five ch3 edges with consumer stalled: four queued, one dropped.
    evt_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_v[3] = ~in_v[3];
      repeat (40) step();
    end
    chk("ovf_set", overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", evt_valid, 1);
      chk("drain_ch", evt_channel, 3);
      chk("drain_rise", evt_rise, (i % 2) == 0);
      step();
    end
    chk("drain_empty", evt_valid, 0);

    // Fill FIFO, then pop exactly on the cycle of the next push.
    evt_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_v[3] = ~in_v[3];
      repeat (40) step();
    end
    in_v[3] = ~in_v[3];
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      hit = m_will_push();
      evt_ready = hit;
      step();
    end
    evt_ready = 1'b0;
    chk("exact_push_seen", hit, 1);
    chk("full_pop_ovf", overflow, 0);
    evt_ready = 1'b1;
    pops = 0;
    repeat (8) begin
      pops += int'(evt_valid);
      step();
    end
    chk("occupancy", pops, 4);

`ifdef DEBOUNCE_SCAN_MASK_EN
    mask_v = 4'b0100;
    evt_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_v[2] = ~in_v[2];
      repeat (40) step();
      chk("mask_state", state[2], in_v[2]);
      chk("mask_no_evt", evt_valid, 0);
    end
    chk("mask_ovf", overflow, 0);
    mask_v = 4'b0000;
`endif

    // Randomized traffic with slow-changing inputs and occasional stalls.
    repeat (2500) begin
      if ($urandom_range(0, 29) == 0) in_v[$urandom_range(0, 3)] ^= 1'b1;
      evt_ready    = ($urandom_range(0, 7) == 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
`ifdef DEBOUNCE_SCAN_MASK_EN
      if ($urandom_range(0, 199) == 0) mask_v = 4'($urandom);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
- Multi-channel debounce controller that shares one debounce counter/compare datapath across NUM_CH noisy inputs (buttons, board straps).
- Channels are served round-robin on a prescaled sample tick. Each channel keeps its own saturating counter and debounced state.
- Debounced edges are queued as events in a small FIFO with a valid/ready interface toward the host-side control logic (FT601 command/status path).

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- MAX_COUNT, 16, consecutive differing samples needed to accept a change.
- TICK_DIV, 1000, clocks per sample tick (>=1).
- FIFO_DEPTH, 4, event queue entries (power of 2, >=2).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in  in  NUM_CH  raw asynchronous inputs.
- state  out  NUM_CH  debounced levels.
- evt_valid  out  1  event available at FIFO head.
- evt_ready  in  1  consumer accepts head event.
- evt_channel  out  clog2(NUM_CH)  channel of head event.
- evt_rise  out  1  1 = rising edge, 0 = falling edge.
- overflow  out  1  sticky: an event was dropped.
- overflow_clr  in  1  one-cycle pulse, clears overflow.

Behaviour:
- Reset, asynchronous on reset_n low, released synchronously: synchronizers, counters, state, tick prescaler, channel pointer, FIFO pointers and overflow all = 0. Hence evt_valid = 0, evt_channel = 0, evt_rise = 0.
- Input synchronizer: 2-flop per channel. The datapath uses the second-stage value s[i].
- Prescaler: counts 0..TICK_DIV-1 and wraps. The tick is asserted for one cycle when count == TICK_DIV-1.
- Channel pointer p: advances on each tick, wrapping NUM_CH-1 -> 0. Each channel is therefore sampled every NUM_CH*TICK_DIV clocks.
- Service of channel p on a tick:
  - If s[p] == state[p]: cnt[p] <= 0.
  - Else if cnt[p] == MAX_COUNT-1: state[p] <= s[p], cnt[p] <= 0, push event {p, s[p]}.
  - Else: cnt[p] <= cnt[p]+1.
- Counter width is clog2(MAX_COUNT), with a minimum of 1 bit. The counter never exceeds MAX_COUNT-1.
- Latency:
  - A state change occurs on the MAX_COUNT-th consecutive differing service of that channel.
  - evt_valid rises the cycle after the push (registered FIFO).
- FIFO and handshake:
  - evt_valid = not empty. Head fields stay stable while evt_valid=1 and evt_ready=0.
  - A pop occurs when evt_valid && evt_ready.
  - Push while full with no pop in the same cycle: the event is dropped, overflow <= 1, and state still updates.
  - Push while full with a pop in the same cycle: the push is accepted and occupancy is unchanged.
  - Push while empty: no same-cycle bypass.
- overflow: set has priority over overflow_clr in the same cycle.
- Order: events leave the FIFO in push order. At most one push per clock, guaranteed by the single shared datapath.

Optional Feature:
- Macro: DEBOUNCE_SCAN_MASK_EN.
- When defined:
  - Adds input port mask [NUM_CH].
  - A channel whose mask bit is 1 still debounces and updates state, but its events are not pushed and never cause overflow.
- When undefined: no mask port; every accepted change is pushed.

Decomposition:
- Shared package: chan_idx width function (clog2 with minimum 1), event field layout constants (EVT_CH_LSB, EVT_RISE_BIT, EVT_W).
- Sub-module: debounce_evt_fifo, a synchronous FIFO with full/empty flags, simultaneous push/pop when full, and asynchronous active-low reset.

Test Plan (NUM_CH=4, MAX_COUNT=4, TICK_DIV=2, FIFO_DEPTH=4; each channel is served every 8 clocks):
- Reset held, inputs toggling -> state=0, evt_valid=0, overflow=0. Assert reset_n low mid-count on ch0, then release and drive in=0001 steady -> ch0 needs a full 4 fresh services before state[0]=1.
- in[2] 0->1 held, evt_ready=1 -> state[2]=1 after the 4th ch2 service. One event evt_channel=2, evt_rise=1. evt_valid is high for exactly 1 clock.
- in[1] high for 2 ch1 services, then low -> no state change, no event, cnt[1] back to 0.
- evt_ready=0, generate 5 edges on ch3 -> 4 events queued in order (rise, fall, rise, fall), overflow=1. Pulse overflow_clr -> overflow=0. Drain -> 4 pops, then evt_valid=0.
- FIFO full, evt_ready=1 on the exact cycle of a new push -> push accepted, overflow stays 0, occupancy stays 4.
- DEBOUNCE_SCAN_MASK_EN with mask=0100 and ch2 toggled -> state[2] follows the input, no event is queued, overflow=0.
